// File: rtl/player_mover.sv
// Maze player-position controller: takes one move request at a time, bounds-checks
// the candidate position, then tests it against three static obstacles (one per
// cycle) before committing or rejecting it. Flags arrival inside the door rectangle.
// Optional build macro: PLAYER_WRAP_EN (horizontal moves wrap around the screen).
module player_mover #(
  parameter int unsigned STEP        = 10,
  parameter int unsigned PLAYER_SIZE = 20,
  parameter int unsigned SCREEN_W    = 800,
  parameter int unsigned SCREEN_H    = 600,
  parameter int unsigned START_X     = 10,
  parameter int unsigned START_Y     = 500,
  parameter int unsigned OBST_SCALE  = 100,
  parameter int unsigned OBST_SIDE   = 100,
  parameter int unsigned DOOR_X      = 700,
  parameter int unsigned DOOR_Y      = 240,
  parameter int unsigned DOOR_W      = 80,
  parameter int unsigned DOOR_H      = 140
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic [17:0] st_obst_xy,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        move_done,
  output logic        move_blocked,
  output logic        at_door,
  output logic [15:0] move_count
);

  localparam int unsigned PW = 11;
  localparam int unsigned WW = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_CHK0, S_CHK1, S_CHK2, S_COMMIT, S_REJECT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      dir_q;
  logic [PW-1:0]   obst_x_q [3];
  logic [PW-1:0]   obst_y_q [3];
  logic [PW-1:0]   cx_q, cy_q;
  logic [PW-1:0]   xpos_q, ypos_q;
  logic [15:0]     move_count_q;
  logic            move_done_q, move_blocked_q, at_door_q;

  logic            accept_c, done_c, blocked_c, commit_c;
  logic [PW-1:0]   cand_x_c, cand_y_c;
  logic            bound_blk_c;
  logic [PW-1:0]   ox_c, oy_c;
  logic            overlap_c;
  logic            door_hit_c;

  assign xpos         = xpos_q;
  assign ypos         = ypos_q;
  assign move_done    = move_done_q;
  assign move_blocked = move_blocked_q;
  assign at_door      = at_door_q;
  assign move_count   = move_count_q;

  // State register
  always_ff @(posedge pclk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = S_CALC;
      S_CALC:   state_d = bound_blk_c ? S_REJECT : S_CHK0;
      S_CHK0:   state_d = overlap_c ? S_REJECT : S_CHK1;
      S_CHK1:   state_d = overlap_c ? S_REJECT : S_CHK2;
      S_CHK2:   state_d = overlap_c ? S_REJECT : S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs and request handshake
  always_comb begin
    move_ready = (state_q == S_IDLE) && !at_door_q;
    accept_c   = move_valid && move_ready;
    commit_c   = (state_q == S_COMMIT);
    blocked_c  = (state_q == S_REJECT);
    done_c     = commit_c || blocked_c;
  end

  // Candidate position and screen-bounds check (unsigned, no underflow)
  always_comb begin
    cand_x_c    = xpos_q;
    cand_y_c    = ypos_q;
    bound_blk_c = 1'b0;
    case (dir_q)
      2'd0: begin
        if (ypos_q < PW'(STEP)) bound_blk_c = 1'b1;
        else                    cand_y_c    = ypos_q - PW'(STEP);
      end
      2'd1: begin
        if (WW'(ypos_q) + WW'(STEP + PLAYER_SIZE) > WW'(SCREEN_H)) bound_blk_c = 1'b1;
        else                                                        cand_y_c    = ypos_q + PW'(STEP);
      end
      2'd2: begin
        if (xpos_q < PW'(STEP)) begin
`ifdef PLAYER_WRAP_EN
          cand_x_c = PW'(SCREEN_W - PLAYER_SIZE);
`else
          bound_blk_c = 1'b1;
`endif
        end else begin
          cand_x_c = xpos_q - PW'(STEP);
        end
      end
      default: begin
        if (WW'(xpos_q) + WW'(STEP + PLAYER_SIZE) > WW'(SCREEN_W)) begin
`ifdef PLAYER_WRAP_EN
          cand_x_c = '0;
`else
          bound_blk_c = 1'b1;
`endif
        end else begin
          cand_x_c = xpos_q + PW'(STEP);
        end
      end
    endcase
  end

  // Overlap test of the registered candidate against the obstacle for this CHK state
  always_comb begin
    case (state_q)
      S_CHK1:  begin ox_c = obst_x_q[1]; oy_c = obst_y_q[1]; end
      S_CHK2:  begin ox_c = obst_x_q[2]; oy_c = obst_y_q[2]; end
      default: begin ox_c = obst_x_q[0]; oy_c = obst_y_q[0]; end
    endcase
    overlap_c = (WW'(cx_q) < WW'(ox_c) + WW'(OBST_SIDE)) &&
                (WW'(cx_q) + WW'(PLAYER_SIZE) > WW'(ox_c)) &&
                (WW'(cy_q) < WW'(oy_c) + WW'(OBST_SIDE)) &&
                (WW'(cy_q) + WW'(PLAYER_SIZE) > WW'(oy_c));
    door_hit_c = (cx_q >= PW'(DOOR_X)) &&
                 (WW'(cx_q) + WW'(PLAYER_SIZE) <= WW'(DOOR_X + DOOR_W)) &&
                 (cy_q >= PW'(DOOR_Y)) &&
                 (WW'(cy_q) + WW'(PLAYER_SIZE) <= WW'(DOOR_Y + DOOR_H));
  end

  // Request latch, obstacle snapshot, candidate capture and commit
  always_ff @(posedge pclk) begin
    if (rst) begin
      dir_q          <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      xpos_q         <= PW'(START_X);
      ypos_q         <= PW'(START_Y);
      move_count_q   <= '0;
      move_done_q    <= 1'b0;
      move_blocked_q <= 1'b0;
      at_door_q      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        obst_x_q[i] <= '0;
        obst_y_q[i] <= '0;
      end
    end else begin
      move_done_q    <= done_c;
      move_blocked_q <= blocked_c;
      if (accept_c) begin
        dir_q <= move_dir;
        for (int i = 0; i < 3; i++) begin
          obst_x_q[i] <= PW'(st_obst_xy[17-6*i -: 3]) * PW'(OBST_SCALE);
          obst_y_q[i] <= PW'(st_obst_xy[14-6*i -: 3]) * PW'(OBST_SCALE);
        end
      end
      if (state_q == S_CALC) begin
        cx_q <= cand_x_c;
        cy_q <= cand_y_c;
      end
      if (commit_c) begin
        xpos_q <= cx_q;
        ypos_q <= cy_q;
        if (move_count_q != 16'hFFFF) move_count_q <= move_count_q + 16'd1;
        if (door_hit_c) at_door_q <= 1'b1;
      end
    end
  end

endmodule
